srlatch_seq: RTL and testbench

Sequencer and arbiter in front of an active-low (NAND) RS latch. It accepts set and clear requests from two independent requesters and converts each into a timed, registered low pulse on the latch's s_n or r_n input. It guarantees that both inputs are never low together, enforces a minimum pulse width and recovery gap, and optionally checks the latch's q output after each operation. It sits between synchronous control logic and an asynchronous latch primitive.

---
 rtl/srlatch_seq_pkg.sv | 30 +++
 rtl/srlatch_seq_if.sv | 39 +++
 rtl/srlatch_seq_sync2.sv | 26 ++
 rtl/srlatch_seq.sv | 152 +++++++++++++++
 tb/tb_srlatch_seq.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/srlatch_seq_pkg.sv
// srlatch_seq_pkg: shared types for the RS-latch sequencer.
// FSM state encoding, grant side type, reset priority and small helpers.
package srlatch_seq_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PULSE   = 2'd1,
        RECOVER = 2'd2,
        ACK     = 2'd3
    } state_t;

    typedef enum logic {
        GNT_SET = 1'b0,
        GNT_CLR = 1'b1
    } grant_t;

    // Side that wins a tie straight out of reset.
    localparam grant_t PRIO_RESET = GNT_SET;

    // Round-robin: the side that did not just win gets the next tie.
    function automatic grant_t other_side(input grant_t g);
        return (g == GNT_SET) ? GNT_CLR : GNT_SET;
    endfunction

    // Latch output expected once an operation has settled.
    function automatic logic expected_q(input grant_t g);
        return (g == GNT_SET) ? 1'b1 : 1'b0;
    endfunction

endpackage

// File: rtl/srlatch_seq_if.sv
// srlatch_seq_if: requester handshakes and latch pins of the sequencer.
// master = requesters plus the latch primitive, slave = the sequencer.
interface srlatch_seq_if;

    logic set_req;
    logic clr_req;
    logic q;
    logic s_n;
    logic r_n;
    logic set_ack;
    logic clr_ack;
    logic busy;
    logic err;

    modport master (
        output set_req,
        output clr_req,
        output q,
        input  s_n,
        input  r_n,
        input  set_ack,
        input  clr_ack,
        input  busy,
        input  err
    );

    modport slave (
        input  set_req,
        input  clr_req,
        input  q,
        output s_n,
        output r_n,
        output set_ack,
        output clr_ack,
        output busy,
        output err
    );

endinterface

// File: rtl/srlatch_seq_sync2.sv
// srlatch_seq_sync2: two-flop synchronizer (the sync2 block) bringing the
// asynchronous latch output into the clk domain. Resets to 0.
module srlatch_seq_sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_r;
    logic sync_r;

    // Two-stage capture so a metastable first stage can resolve.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_r <= 1'b0;
            sync_r <= 1'b0;
        end else begin
            meta_r <= d;
            sync_r <= meta_r;
        end
    end

    assign q = sync_r;

endmodule

// File: rtl/srlatch_seq.sv
// srlatch_seq: arbitrates set/clear requests and turns each into a timed,
// registered active-low pulse on a NAND RS latch (s_n or r_n, never both),
// followed by a recovery gap and a one-cycle ack.
// Optional latch read-back check is enabled by defining SRLATCH_SEQ_VERIFY_EN;
// without it the synchronizer is omitted and err stays 0.
module srlatch_seq
    import srlatch_seq_pkg::*;
#(
    parameter int PULSE_CYCLES   = 4,
    parameter int RECOVER_CYCLES = 3,
    parameter int CNT_W          = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    srlatch_seq_if.slave   bus
);

    // Counter runs down to zero, so it is loaded with length minus one.
    localparam logic [CNT_W-1:0] PULSE_LOAD   = CNT_W'(PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] RECOVER_LOAD = CNT_W'(RECOVER_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO     = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE      = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state_r, state_s;
    grant_t           gnt_r, gnt_s;
    grant_t           prio_r, prio_s;
    logic [CNT_W-1:0] cnt_r, cnt_s;
    logic             s_n_r, s_n_s;
    logic             r_n_r, r_n_s;
    logic             set_ack_r, set_ack_s;
    logic             clr_ack_r, clr_ack_s;
    logic             busy_r, busy_s;
    logic             err_r, err_s;
    logic             verify_fail_s;

`ifdef SRLATCH_SEQ_VERIFY_EN
    logic q_sync_s;

    srlatch_seq_sync2 u_sync2 (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (bus.q),
        .q     (q_sync_s)
    );

    // Compare the settled latch output in the final recovery cycle.
    always_comb begin
        if ((state_r == RECOVER) && (cnt_r == CNT_ZERO)) begin
            verify_fail_s = (q_sync_s != expected_q(gnt_r));
        end else begin
            verify_fail_s = 1'b0;
        end
    end
`else
    logic unused_q_s;
    assign unused_q_s    = bus.q;
    assign verify_fail_s = 1'b0;
`endif

    // Next-state, grant arbitration, counter and next output values.
    always_comb begin
        state_s = state_r;
        gnt_s   = gnt_r;
        prio_s  = prio_r;
        cnt_s   = cnt_r;

        case (state_r)
            IDLE: begin
                if (bus.set_req || bus.clr_req) begin
                    if (bus.set_req && bus.clr_req) begin
                        gnt_s = prio_r;
                    end else if (bus.set_req) begin
                        gnt_s = GNT_SET;
                    end else begin
                        gnt_s = GNT_CLR;
                    end
                    prio_s  = other_side(gnt_s);
                    cnt_s   = PULSE_LOAD;
                    state_s = PULSE;
                end else begin
                    state_s = IDLE;
                end
            end
            PULSE: begin
                if (cnt_r == CNT_ZERO) begin
                    cnt_s   = RECOVER_LOAD;
                    state_s = RECOVER;
                end else begin
                    cnt_s = cnt_r - CNT_ONE;
                end
            end
            RECOVER: begin
                if (cnt_r == CNT_ZERO) begin
                    state_s = ACK;
                end else begin
                    cnt_s = cnt_r - CNT_ONE;
                end
            end
            ACK: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
                cnt_s   = CNT_ZERO;
            end
        endcase

        // Outputs are decoded from the next state so they register in step
        // with it; a single grant means only one side can ever be low.
        s_n_s     = !((state_s == PULSE) && (gnt_s == GNT_SET));
        r_n_s     = !((state_s == PULSE) && (gnt_s == GNT_CLR));
        set_ack_s = (state_s == ACK) && (gnt_s == GNT_SET);
        clr_ack_s = (state_s == ACK) && (gnt_s == GNT_CLR);
        busy_s    = (state_s != IDLE);
        err_s     = err_r | verify_fail_s;
    end

    // State, counter and registered outputs; reset forces latch inputs high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            gnt_r     <= GNT_SET;
            prio_r    <= PRIO_RESET;
            cnt_r     <= CNT_ZERO;
            s_n_r     <= 1'b1;
            r_n_r     <= 1'b1;
            set_ack_r <= 1'b0;
            clr_ack_r <= 1'b0;
            busy_r    <= 1'b0;
            err_r     <= 1'b0;
        end else begin
            state_r   <= state_s;
            gnt_r     <= gnt_s;
            prio_r    <= prio_s;
            cnt_r     <= cnt_s;
            s_n_r     <= s_n_s;
            r_n_r     <= r_n_s;
            set_ack_r <= set_ack_s;
            clr_ack_r <= clr_ack_s;
            busy_r    <= busy_s;
            err_r     <= err_s;
        end
    end

    assign bus.s_n     = s_n_r;
    assign bus.r_n     = r_n_r;
    assign bus.set_ack = set_ack_r;
    assign bus.clr_ack = clr_ack_r;
    assign bus.busy    = busy_r;
    assign bus.err     = err_r;

endmodule

// File: tb/tb_srlatch_seq.sv
// tb_srlatch_seq: directed bench for srlatch_seq with a behavioural NAND
// latch model (optionally stuck low). Trace bits per cycle are
// {s_n, r_n, set_ack, clr_ack, busy, err}.
module tb_srlatch_seq;

    localparam int P  = 4;
    localparam int R  = 3;
    localparam int OP = P + R + 2;

`ifdef SRLATCH_SEQ_VERIFY_EN
    localparam bit ERR_ON = 1'b1;
`else
    localparam bit ERR_ON = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    srlatch_seq_if bus ();

    srlatch_seq #(
        .PULSE_CYCLES   (P),
        .RECOVER_CYCLES (R),
        .CNT_W          (8)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Latch model: set on s_n low, clear on r_n low; can be forced stuck at 0.
    logic q_latch   = 1'b0;
    logic stuck_low = 1'b0;
    always @(bus.s_n or bus.r_n) begin
        if (bus.s_n === 1'b0) q_latch = 1'b1;
        else if (bus.r_n === 1'b0) q_latch = 1'b0;
    end
    assign bus.q = stuck_low ? 1'b0 : q_latch;

    // Count any cycle in which both latch inputs are low.
    int   overlap_cnt = 0;
    logic mon_en      = 1'b0;
    always @(negedge clk) begin
        if (mon_en && (bus.s_n === 1'b0) && (bus.r_n === 1'b0)) overlap_cnt++;
    end

    logic [5:0] tr [0:63];
    logic       hold_reqs = 1'b0;
    int         n_checks  = 0;
    int         n_fail    = 0;

    // Record n cycles of outputs starting at index first; requesters drop on ack.
    task automatic capture(input int first, input int n);
        for (int i = first; i < first + n; i++) begin
            @(posedge clk); #1;
            tr[i] = {bus.s_n, bus.r_n, bus.set_ack, bus.clr_ack, bus.busy, bus.err};
            if (!hold_reqs) begin
                if (bus.set_ack) bus.set_req = 1'b0;
                if (bus.clr_ack) bus.clr_req = 1'b0;
            end
        end
    endtask

    task automatic do_reset();
        bus.set_req = 1'b0;
        bus.clr_req = 1'b0;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        logic [5:0] got;
        bus.set_req = 1'b0;
        bus.clr_req = 1'b0;
        rst_n = 1'b0; #1;
        got = {bus.s_n, bus.r_n, bus.set_ack, bus.clr_ack, bus.busy, bus.err};
        n_checks++;
        if (got !== 6'b110000) begin n_fail++; $display("FAIL reset_async: got %b expected 110000", got); end
        @(posedge clk); #1;
        got = {bus.s_n, bus.r_n, bus.set_ack, bus.clr_ack, bus.busy, bus.err};
        n_checks++;
        if (got !== 6'b110000) begin n_fail++; $display("FAIL reset_held: got %b expected 110000", got); end
        rst_n  = 1'b1;
        mon_en = 1'b1;
        @(posedge clk); #1;
        got = {bus.s_n, bus.r_n, bus.set_ack, bus.clr_ack, bus.busy, bus.err};
        n_checks++;
        if (got !== 6'b110000) begin n_fail++; $display("FAIL reset_idle: got %b expected 110000", got); end
    endtask

    task automatic test_single_set();
        logic [5:0] exp;
        do_reset();
        bus.set_req = 1'b1;
        capture(0, OP);
        for (int i = 0; i < OP; i++) begin
            exp = {!(i < P), 1'b1, (i == P + R), 1'b0, (i <= P + R), 1'b0};
            n_checks++;
            if (tr[i] !== exp) begin n_fail++; $display("FAIL single_set[%0d]: got %b expected %b", i, tr[i], exp); end
        end
    endtask

    task automatic test_simultaneous();
        logic [5:0] exp;
        int k, j;
        do_reset();
        bus.set_req = 1'b1;
        bus.clr_req = 1'b1;
        capture(0, 2 * OP);
        for (int i = 0; i < 2 * OP; i++) begin
            k = i / OP;
            j = i % OP;
            exp = {!((j < P) && (k == 0)), !((j < P) && (k == 1)),
                   (j == P + R) && (k == 0), (j == P + R) && (k == 1), (j <= P + R), 1'b0};
            n_checks++;
            if (tr[i] !== exp) begin n_fail++; $display("FAIL simultaneous[%0d]: got %b expected %b", i, tr[i], exp); end
        end
    endtask

    task automatic test_round_robin();
        logic [5:0] exp;
        int k, j;
        do_reset();
        hold_reqs   = 1'b1;
        bus.set_req = 1'b1;
        bus.clr_req = 1'b1;
        capture(0, 4 * OP - 1);
        bus.set_req = 1'b0;
        bus.clr_req = 1'b0;
        hold_reqs   = 1'b0;
        capture(4 * OP - 1, 2);
        for (int i = 0; i < 4 * OP + 1; i++) begin
            k = i / OP;
            j = i % OP;
            if (k > 3) begin
                exp = 6'b110000;
            end else begin
                exp = {!((j < P) && (k % 2 == 0)), !((j < P) && (k % 2 == 1)),
                       (j == P + R) && (k % 2 == 0), (j == P + R) && (k % 2 == 1), (j <= P + R), 1'b0};
            end
            n_checks++;
            if (tr[i] !== exp) begin n_fail++; $display("FAIL round_robin[%0d]: got %b expected %b", i, tr[i], exp); end
        end
    endtask

    task automatic test_reset_mid_pulse();
        logic [5:0] got;
        logic [5:0] exp;
        do_reset();
        bus.set_req = 1'b1;
        capture(0, 2);
        n_checks++;
        if (tr[1] !== 6'b010010) begin n_fail++; $display("FAIL mid_pulse_before: got %b expected 010010", tr[1]); end
        rst_n = 1'b0; #1;
        got = {bus.s_n, bus.r_n, bus.set_ack, bus.clr_ack, bus.busy, bus.err};
        n_checks++;
        if (got !== 6'b110000) begin n_fail++; $display("FAIL mid_pulse_async: got %b expected 110000", got); end
        @(posedge clk); #1;
        got = {bus.s_n, bus.r_n, bus.set_ack, bus.clr_ack, bus.busy, bus.err};
        n_checks++;
        if (got !== 6'b110000) begin n_fail++; $display("FAIL mid_pulse_no_ack: got %b expected 110000", got); end
        rst_n = 1'b1;
        capture(0, OP);
        for (int i = 0; i < OP; i++) begin
            exp = {!(i < P), 1'b1, (i == P + R), 1'b0, (i <= P + R), 1'b0};
            n_checks++;
            if (tr[i] !== exp) begin n_fail++; $display("FAIL mid_pulse_restart[%0d]: got %b expected %b", i, tr[i], exp); end
        end
    endtask

    task automatic test_dropped_req();
        logic [5:0] exp;
        do_reset();
        bus.set_req = 1'b1;
        capture(0, 1);
        bus.set_req = 1'b0;
        capture(1, OP - 1);
        for (int i = 0; i < OP; i++) begin
            exp = {!(i < P), 1'b1, (i == P + R), 1'b0, (i <= P + R), 1'b0};
            n_checks++;
            if (tr[i] !== exp) begin n_fail++; $display("FAIL dropped_req[%0d]: got %b expected %b", i, tr[i], exp); end
        end
    endtask

    task automatic test_verify();
        logic [5:0] exp;
        do_reset();
        stuck_low   = 1'b1;
        bus.set_req = 1'b1;
        capture(0, OP);
        for (int i = 0; i < OP; i++) begin
            exp = {!(i < P), 1'b1, (i == P + R), 1'b0, (i <= P + R), ERR_ON && (i >= P + R)};
            n_checks++;
            if (tr[i] !== exp) begin n_fail++; $display("FAIL verify_stuck[%0d]: got %b expected %b", i, tr[i], exp); end
        end
        stuck_low   = 1'b0;
        bus.clr_req = 1'b1;
        capture(0, OP);
        for (int i = 0; i < OP; i++) begin
            exp = {1'b1, !(i < P), 1'b0, (i == P + R), (i <= P + R), ERR_ON};
            n_checks++;
            if (tr[i] !== exp) begin n_fail++; $display("FAIL verify_sticky_clr[%0d]: got %b expected %b", i, tr[i], exp); end
        end
        bus.set_req = 1'b1;
        capture(0, OP);
        for (int i = 0; i < OP; i++) begin
            exp = {!(i < P), 1'b1, (i == P + R), 1'b0, (i <= P + R), ERR_ON};
            n_checks++;
            if (tr[i] !== exp) begin n_fail++; $display("FAIL verify_sticky_set[%0d]: got %b expected %b", i, tr[i], exp); end
        end
    endtask

    // Hard time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.set_req = 1'b0;
        bus.clr_req = 1'b0;
        #3;
        test_reset();
        test_single_set();
        test_simultaneous();
        test_round_robin();
        test_reset_mid_pulse();
        test_dropped_req();
        test_verify();
        n_checks++;
        if (overlap_cnt !== 0) begin
            n_fail++;
            $display("FAIL no_overlap: got %0d overlapping cycles expected 0", overlap_cnt);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
